util_axis_1553_word_gen: RTL
============================

# util_axis_1553_word_gen

Synthesizable, parametrised MIL-STD-1553 word generator that takes 16-bit words on an AXI-Stream slave and drives Manchester II biphase onto the `diff` pair at 1 Mbit/s. Clock rate, inter-word gap and error injection are configurable. It serves as the transmit path of the open1553 core and as an in-fabric stimulus source for `util_axis_1553_decoder` in loopback.

## Interface
- `clock_speed`, 100000000: `aclk` frequency in Hz; CPB = `clock_speed`/1000000 must be an even integer ≥ 2.
- `gap_cycles`, 0: minimum idle `aclk` cycles between consecutive words; range 0..65535.
- `aclk` input 1: clock.
- `arstn` input 1: reset, asynchronous, active-low.
- `s_axis_tdata` input 16: data word, transmitted MSB first.
- `s_axis_tvalid` input 1: word valid.
- `s_axis_tuser` input 8:
  - [0] sync type, 1 = command/status, 0 = data.
  - [1] parity-invert, only with the macro.
  - [2] Manchester-error, only with the macro.
  - [7:3] reserved, ignored.
- `s_axis_tready` output 1: word accepted on `tvalid & tready`.
- `diff` output 2: [0] positive leg, [1] negative leg.

## Operation
- FSM states are IDLE, SYNC, DATA, PARITY and GAP.
- Counters:
  - `cyc_cnt` runs 0..CPB-1 per bit time.
  - `bit_cnt` counts sync (3 bits) and data (15..0).
  - `gap_cnt` counts the idle gap.
- IDLE:
  - `diff`=2'b00 and `s_axis_tready`=1.
  - On handshake, latch tdata and tuser, compute parity p = ~^tdata, then go to SYNC.
- SYNC:
  - Lasts 3·CPB cycles.
  - Command/status sync: `diff`=2'b01 for 1.5·CPB cycles, then 2'b10 for 1.5·CPB.
  - Data sync is the inverse: 2'b10 then 2'b01.
- DATA:
  - 16 bits of CPB cycles each, bit 15 first.
  - Logic 1 = 2'b01 for the first CPB/2 cycles, then 2'b10.
  - Logic 0 = 2'b10 then 2'b01.
- PARITY: one bit time encoded like DATA using p, then go to GAP.
- GAP:
  - `diff`=2'b00 for `gap_cycles` cycles, then return to IDLE.
  - With `gap_cycles`=0 the GAP state is skipped.
- Back-to-back:
  - When `gap_cycles`=0, `s_axis_tready` is also 1 on the last PARITY cycle.
  - A handshake in that cycle goes directly to SYNC with no idle cycle between words.
- While active, `diff[1]` is always ~`diff[0]`; 2'b11 is never driven.
- A `tvalid` low in IDLE holds IDLE. Data changes while `tready`=0 are ignored.

## Timing
- All outputs are registered.
- Reset values: `diff`=2'b00, `s_axis_tready`=0, state IDLE, all counters 0.
- Reset deassertion: `tready` rises on the first `aclk` edge after `arstn` goes high.
- Latency: a handshake at edge N gives the first sync level on `diff` at edge N+1.
- Word duration is exactly 20·CPB cycles.
- Word pitch is 20·CPB + `gap_cycles` cycles.
- Reset mid-word:
  - `diff` goes to 2'b00 and `tready` to 0 asynchronously.
  - The word in flight is discarded and not resent.

## Configuration
- `UTIL_AXIS_1553_WORD_GEN_ERR_INJ_EN` defined:
  - tuser[1]=1 transmits ~p.
  - tuser[2]=1 holds bit 15 at its first-half level for the full bit time (no mid-bit transition).
- Not defined: tuser[2:1] are ignored and the injection logic is not synthesized.

## Structure
- Package `util_axis_1553_pkg` holds the shared constants and types:
  - BIT_RATE_HZ=1000000, SYNC_BITS=3, DATA_BITS=16, WORD_BITS=20.
  - The FSM state typedef.
  - The tuser bit-index constants, shared with the decoder.
- One sub-module, `util_axis_1553_bit_timer`:
  - Parametrised by CPB.
  - Produces `half_tick` (cycle CPB/2-1), `bit_tick` (cycle CPB-1) and `sync_mid_tick` (cycle 1.5·CPB-1).
  - Restarts on a start pulse.

## Test plan
All cases use `clock_speed`=100000000, so CPB=100.
- **Command word, all ones:** 16'hFFFF, tuser=8'h01, `gap_cycles`=0.
  - `diff`: 150 cycles 2'b01, then 150 cycles 2'b10.
  - Then 16×(50 cycles 01, 50 cycles 10), then parity 1 (01/10).
  - Then 2'b00; 2000 active cycles in total.
- **Data word, all zeros:** 16'h0000, tuser=8'h00.
  - Sync is 150 cycles 10 then 150 cycles 01.
  - Each data bit is 10/01; parity is 1.
- **Back-to-back:** `gap_cycles`=0, two words with `tvalid` held high.
  - 4000 contiguous active cycles with no 2'b00.
  - `tready` is sampled high on exactly 2 handshakes.
- **Gap:** `gap_cycles`=400, two words.
  - The second word's first sync level appears 2400 cycles after the first word's first sync level.
- **Reset mid-word:** drop `arstn` 500 cycles into a word.
  - `diff`=00 and `tready`=0 immediately.
  - After release, `tready`=1 the next edge and no residual word is output.
- **Error injection:** macro defined, 16'h0001 with tuser=8'h03 gives parity 1 (nominal 0).
  - Without the macro the same stimulus gives parity 0.

Source files
------------

// File: rtl/util_axis_1553_pkg.sv
// Shared constants and types for the util_axis_1553 word generator and decoder.
// Error injection is enabled by UTIL_AXIS_1553_WORD_GEN_ERR_INJ_EN.
package util_axis_1553_pkg;

  localparam int BIT_RATE_HZ = 1000000;
  localparam int SYNC_BITS   = 3;
  localparam int DATA_BITS   = 16;
  localparam int WORD_BITS   = 20;

  localparam int TUSER_SYNC    = 0;
  localparam int TUSER_PAR_INV = 1;
  localparam int TUSER_MAN_ERR = 2;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    PARITY,
    GAP
  } state_t;

  typedef struct packed {
    logic [15:0] data;
    logic        cmd;
    logic        par;
    logic        merr;
  } word_t;

endpackage

// File: rtl/util_axis_1553_bit_timer.sv
// Per-bit cycle counter for the 1553 encoder; restarts on start.
// Ticks mark mid-bit, end-of-bit, end-of-bit minus one and sync midpoint.
module util_axis_1553_bit_timer #(
  parameter int CPB = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic half_tick,
  output logic bit_tick,
  output logic pre_bit_tick,
  output logic sync_mid_tick
);

  localparam int W = $clog2(CPB);

  logic [W-1:0] cyc_cnt;
  logic         phase;

  assign bit_tick      = (cyc_cnt == W'(CPB - 1));
  assign pre_bit_tick  = (cyc_cnt == W'(CPB - 2));
  assign half_tick     = (cyc_cnt == W'(CPB / 2 - 1));
  // phase is high in odd bits, so this lands at 1.5 bit times
  assign sync_mid_tick = phase & half_tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt <= '0;
      phase   <= 1'b0;
    end else if (start) begin
      cyc_cnt <= '0;
      phase   <= 1'b0;
    end else if (bit_tick) begin
      cyc_cnt <= '0;
      phase   <= ~phase;
    end else begin
      cyc_cnt <= cyc_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/util_axis_1553_word_gen.sv
// MIL-STD-1553 Manchester II word generator fed from AXI-Stream.
// Define UTIL_AXIS_1553_WORD_GEN_ERR_INJ_EN to enable parity/Manchester error injection.
module util_axis_1553_word_gen
  import util_axis_1553_pkg::*;
#(
  parameter int clock_speed = 100000000,
  parameter int gap_cycles  = 0
) (
  input  logic        aclk,
  input  logic        arstn,
  input  logic [15:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic [7:0]  s_axis_tuser,
  output logic        s_axis_tready,
  output logic [1:0]  diff
);

  localparam int CPB = clock_speed / BIT_RATE_HZ;
  localparam logic [15:0] GAP_LAST =
    16'((gap_cycles >= 2) ? gap_cycles - 2 : 0);

  state_t      state, state_d;
  logic [3:0]  bit_cnt, bit_cnt_d;
  logic [15:0] gap_cnt, gap_cnt_d;
  word_t       word_q, word_d;
  logic        first_half, sync_late;
  logic        half_tick, bit_tick;
  logic        pre_bit_tick, sync_mid_tick;
  logic        hs, lvl, tready_d;
  logic [1:0]  diff_d;
  logic        unused_tuser;

  assign hs = s_axis_tvalid & s_axis_tready;

`ifdef UTIL_AXIS_1553_WORD_GEN_ERR_INJ_EN
  assign word_d = '{
    data: s_axis_tdata,
    cmd:  s_axis_tuser[TUSER_SYNC],
    par:  ~^s_axis_tdata ^ s_axis_tuser[TUSER_PAR_INV],
    merr: s_axis_tuser[TUSER_MAN_ERR]
  };
  assign unused_tuser = ^s_axis_tuser[7:3];
`else
  assign word_d = '{
    data: s_axis_tdata,
    cmd:  s_axis_tuser[TUSER_SYNC],
    par:  ~^s_axis_tdata,
    merr: 1'b0
  };
  assign unused_tuser = ^s_axis_tuser[7:1];
`endif

  util_axis_1553_bit_timer #(
    .CPB(CPB)
  ) u_bit_timer (
    .clk          (aclk),
    .rst_n        (arstn),
    .start        (hs),
    .half_tick    (half_tick),
    .bit_tick     (bit_tick),
    .pre_bit_tick (pre_bit_tick),
    .sync_mid_tick(sync_mid_tick)
  );

  always_comb begin
    state_d   = state;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    unique case (state)
      IDLE: begin
        if (hs) begin
          state_d   = SYNC;
          bit_cnt_d = '0;
        end
      end
      SYNC: begin
        if (bit_tick) begin
          if (bit_cnt == 4'(SYNC_BITS - 1)) begin
            state_d   = DATA;
            bit_cnt_d = 4'(DATA_BITS - 1);
          end else begin
            bit_cnt_d = bit_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_cnt == 4'd0) state_d = PARITY;
          else bit_cnt_d = bit_cnt - 1'b1;
        end
      end
      PARITY: begin
        if (bit_tick) begin
          gap_cnt_d = '0;
          if (hs) begin
            state_d   = SYNC;
            bit_cnt_d = '0;
          end else if (gap_cycles <= 1) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_d = IDLE;
        else gap_cnt_d = gap_cnt + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // The IDLE cycle that follows GAP supplies the last idle cycle of the gap
  assign tready_d = (state_d == IDLE) ||
                    ((gap_cycles == 0) && (state == PARITY) && pre_bit_tick);

  // lvl=1 drives 2'b01, lvl=0 drives 2'b10
  always_comb begin
    lvl    = 1'b0;
    diff_d = 2'b00;
    unique case (1'b1)
      (state == SYNC): begin
        lvl    = word_q.cmd ^ sync_late;
        diff_d = lvl ? 2'b01 : 2'b10;
      end
      (state == DATA): begin
        lvl    = word_q.data[bit_cnt] ^ ~(first_half |
                 (word_q.merr & (bit_cnt == 4'd15)));
        diff_d = lvl ? 2'b01 : 2'b10;
      end
      (state == PARITY): begin
        lvl    = word_q.par ^ ~first_half;
        diff_d = lvl ? 2'b01 : 2'b10;
      end
      default: diff_d = 2'b00;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
      word_q        <= '0;
      first_half    <= 1'b0;
      sync_late     <= 1'b0;
      diff          <= 2'b00;
      s_axis_tready <= 1'b0;
    end else begin
      state         <= state_d;
      bit_cnt       <= bit_cnt_d;
      gap_cnt       <= gap_cnt_d;
      diff          <= diff_d;
      s_axis_tready <= tready_d;
      if (hs) word_q <= word_d;
      if (hs || bit_tick) first_half <= 1'b1;
      else if (half_tick) first_half <= 1'b0;
      if (hs) sync_late <= 1'b0;
      else if (state == SYNC && sync_mid_tick) sync_late <= 1'b1;
    end
  end

endmodule
